// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampled UART receiver with a one-entry valid/ready holding
//            register. Optional parity checking via UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_tick_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = $clog2(DATA_BITS);
  localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE/2 - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;

  state_t                 r_state, w_state_nxt;
  logic [c_tick_w-1:0]    r_tick_cnt, w_tick_nxt;
  logic [c_bit_w-1:0]     r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   w_commit;

  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  always_ff @(posedge clk) begin
    if (!arst_n) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  // r_par folds data XOR, received parity and parity_odd: 1 at STOP means error.
  logic r_par, w_par_nxt;
  logic r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (rx_clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == c_tick_mid) begin
            if (w_rx_s) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
              w_par_nxt   = 1'b0;
`endif
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            w_par_nxt   = r_par ^ w_rx_s;
            if (r_bit_cnt == c_bit_last) w_state_nxt = S_PARITY;
`else
            if (r_bit_cnt == c_bit_last) w_state_nxt = S_STOP;
`endif
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_nxt  = '0;
            w_par_nxt   = r_par ^ w_rx_s ^ parity_odd;
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_tick_cnt == c_tick_last) begin
            w_tick_nxt  = '0;
            w_commit    = 1'b1;
            w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Holding register: a commit into a full, unaccepted slot is dropped.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_commit) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_rx_valid   <= 1'b1;
          r_frame_err  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
          r_parity_err <= r_par;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Scoreboard bench for uart_rx: serial frames driven bit-by-bit, expected bytes
// queued at send time and popped by a monitor on each valid/ready handshake.
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Ticks from the start-detect tick to the stop-bit mid-sample.
  localparam int STOP_TICKS = 8 + 16 * (FRAME_BITS - 1);

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx_clk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif

  uart_rx dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .rx_clk_en  (rx_clk_en),
    .rx         (rx),
    .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 rx_clk_en = 1'b1;
      @(posedge clk);
      #1 rx_clk_en = 1'b0;
    end
  end

  int         checks = 0;
  int         failures = 0;
  int         ov_seen = 0;
  int         exp_ov = 0;
  logic [9:0] exp_q[$];   // {parity_err, frame_err, data}
  logic [9:0] mon_e;

  always @(negedge clk) begin
    if (arst_n) begin
      if (overrun) ov_seen++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame actual data=%02h fe=%0b pe=%0b required=no frame",
                   rx_data, frame_err, parity_err);
        end else begin
          mon_e = exp_q.pop_front();
          if ({parity_err, frame_err, rx_data} !== mon_e) begin
            failures++;
            $display("FAIL frame actual pe=%0b fe=%0b data=%02h required pe=%0b fe=%0b data=%02h",
                     parity_err, frame_err, rx_data, mon_e[9], mon_e[8], mon_e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  // Begins one cycle-aligned edge after the call; par is ignored without parity.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx = 1'b0;
`endif
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
    rx = 1'b1;
  endtask

  function automatic logic exp_pe(input logic [7:0] d, input logic par, input logic odd);
`ifdef UART_RX_PARITY_EN
    return par != ((^d) ^ odd);
`else
    if (odd === 1'bx && par === 1'bx) return d[0] & 1'b0;
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    exp_q.push_back({pe, fe, d});
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // Raises rx_ready exactly in the tick cycle where the stop bit is sampled.
  task automatic ready_at_stop_sample();
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    while (!rx_clk_en) begin @(posedge clk); #2; end
    for (int t = 0; t < STOP_TICKS; t++) begin
      @(posedge clk);
      #2;
      while (!rx_clk_en) begin @(posedge clk); #2; end
    end
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  logic [7:0] b;
  logic       stp, par;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {frame_err, parity_err, overrun}, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Single frame held until accepted
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    repeat (5) @(posedge clk);
    #1;
    chk("single_valid", rx_valid, 1);
    chk("single_data", rx_data, 8'hA5);
    chk("single_fe", frame_err, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("single_hold", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("single_clear", rx_valid, 0);
    chk("single_popped", exp_q.size(), 0);

    // Glitch rejection
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_busy_up", busy, 1);
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_busy_down", busy, 0);
    repeat (100) @(posedge clk);

    // Overrun: second back-to-back frame dropped
    rx_ready = 1'b0;
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    exp_ov++;
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_pulses", ov_seen, exp_ov);
    drain("ovr_drain");

    // Ready in the commit cycle: no overrun, new byte loaded
    rx_ready = 1'b0;
    push(8'h3C, 1'b0, 1'b0);
    push(8'hC3, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    fork
      send_frame(8'hC3, 1'b1, ^8'hC3);
      ready_at_stop_sample();
    join
    repeat (10) @(posedge clk);
    #1;
    chk("same_cycle_data", rx_data, 8'hC3);
    chk("same_cycle_ovr", ov_seen, exp_ov);
    drain("same_cycle_drain");

    // Break: one frame, busy until line returns high
    rx_ready = 1'b1;
    push(8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3 * FRAME_BITS * BIT_CLK) @(posedge clk);
    #1;
    chk("break_busy", busy, 1);
    chk("break_one_frame", exp_q.size(), 0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("break_busy_down", busy, 0);
    repeat (100) @(posedge clk);

    // Randomized frames against the reference model
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 5) != 0);
      par = (^b) ^ ($urandom_range(0, 3) == 0);
      push(b, ~stp, exp_pe(b, par, 1'b0));
      send_frame(b, stp, par);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    drain("random_drain");
    chk("random_no_ovr", ov_seen, exp_ov);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    push(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    push(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    parity_odd = 1'b1;
    push(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    parity_odd = 1'b0;
    drain("parity_drain");
`endif

    // Reset mid-frame with a byte already held
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    repeat (5) @(posedge clk);
    #1;
    chk("held_before_reset", rx_valid, 1);
    @(posedge clk);
    #1;
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (32) @(posedge clk);
    #1;
    arst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_valid", rx_valid, 0);
    chk("midreset_data", rx_data, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_flags", {frame_err, parity_err, overrun}, 0);
    arst_n = 1'b1;
    repeat (100) @(posedge clk);
    rx_ready = 1'b1;
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, ^8'h81);
    drain("after_reset_drain");
    chk("final_ovr", ov_seen, exp_ov);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
